// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller: 4-deep job FIFO feeding a motor/coin-ejector sequencer.
// Optional macro DISPENSE_STATS_EN builds a saturating dispensed-product counter on vend_cnt.
module vend_dispense_ctrl #(
    parameter int MOTOR_CYC = 8,
    parameter int EJECT_ON  = 2,
    parameter int EJECT_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic [1:0] change,
    input  logic       hopper_empty,
    output logic       prod_motor,
    output logic       coin_eject,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       coin_short,
    output logic [7:0] vend_cnt,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOTOR  = 3'd1,
        S_EJ_ON  = 3'd2,
        S_EJ_GAP = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYC - 1);
    localparam logic [7:0] ON_LAST    = 8'(EJECT_ON - 1);
    localparam logic [7:0] GAP_LAST   = 8'(EJECT_GAP - 1);

    // Job FIFO: entry = {vend, change}; handshake is push when a job is seen, pop when IDLE and non-empty.
    logic [2:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       push_req, push_ok, pop, fifo_empty, fifo_full;
    logic [2:0] head;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] coins_q, coins_d;
    logic       short_set;
    logic       prod_motor_q, coin_eject_q, done_q, overflow_q, coin_short_q;

    assign push_req   = out | (|change);
    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop);
    assign head       = fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= {out, change};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + 3'(push_ok) - 3'(pop);
            if (push_req && !push_ok) overflow_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        coins_d   = coins_q;
        short_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    cnt_d   = 8'd0;
                    coins_d = head[1:0];
                    if (head[2]) begin
                        state_d = S_MOTOR;
                    end else if (hopper_empty) begin
                        state_d   = S_DONE;
                        coins_d   = 2'd0;
                        short_set = 1'b1;
                    end else begin
                        state_d = S_EJ_ON;
                    end
                end
            end
            S_MOTOR: begin
                if (cnt_q == MOTOR_LAST) begin
                    cnt_d = 8'd0;
                    if (coins_q == 2'd0) begin
                        state_d = S_DONE;
                    end else if (hopper_empty) begin
                        state_d   = S_DONE;
                        coins_d   = 2'd0;
                        short_set = 1'b1;
                    end else begin
                        state_d = S_EJ_ON;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EJ_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d   = 8'd0;
                    coins_d = coins_q - 2'd1;
                    state_d = S_EJ_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EJ_GAP: begin
                // Hopper is only consulted when a new pulse would start, never mid-pulse.
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 8'd0;
                    if (coins_q == 2'd0) begin
                        state_d = S_DONE;
                    end else if (hopper_empty) begin
                        state_d   = S_DONE;
                        coins_d   = 2'd0;
                        short_set = 1'b1;
                    end else begin
                        state_d = S_EJ_ON;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            coins_q      <= 2'd0;
            prod_motor_q <= 1'b0;
            coin_eject_q <= 1'b0;
            done_q       <= 1'b0;
            coin_short_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            coins_q      <= coins_d;
            prod_motor_q <= (state_d == S_MOTOR);
            coin_eject_q <= (state_d == S_EJ_ON);
            done_q       <= (state_d == S_DONE);
            coin_short_q <= coin_short_q | short_set;
        end
    end

`ifdef DISPENSE_STATS_EN
    logic [7:0] vend_cnt_q;
    logic       motor_done;

    assign motor_done = (state_q == S_MOTOR) && (cnt_q == MOTOR_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            vend_cnt_q <= 8'd0;
        end else if (motor_done && (vend_cnt_q != 8'hFF)) begin
            vend_cnt_q <= vend_cnt_q + 8'd1;
        end
    end

    assign vend_cnt = vend_cnt_q;
`else
    assign vend_cnt = 8'd0;
`endif

    assign prod_motor  = prod_motor_q;
    assign coin_eject  = coin_eject_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign coin_short  = coin_short_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: hand-computed cycle-by-cycle drive patterns.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       out;
    logic [1:0] change;
    logic       hopper_empty;
    logic       prod_motor, coin_eject, busy, done, overflow, coin_short;
    logic [7:0] vend_cnt;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

`ifdef DISPENSE_STATS_EN
    localparam logic [7:0] EXP_AFTER_ONE = 8'd1;
    localparam int         N_VENDS       = 300;
    localparam logic [7:0] EXP_AFTER_N   = 8'd255;
`else
    localparam logic [7:0] EXP_AFTER_ONE = 8'd0;
    localparam int         N_VENDS       = 3;
    localparam logic [7:0] EXP_AFTER_N   = 8'd0;
`endif

    vend_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .out          (out),
        .change       (change),
        .hopper_empty (hopper_empty),
        .prod_motor   (prod_motor),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .coin_short   (coin_short),
        .vend_cnt     (vend_cnt),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    // Drives must never overlap, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert (!(prod_motor === 1'b1 && coin_eject === 1'b1)) else begin
                errors++;
                $error("FAIL mutex: observed motor=%0b eject=%0b expected not both 1", prod_motor, coin_eject);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_drv(input string tag, input logic m, input logic e, input logic d);
        chk1({tag, ".motor"}, prod_motor, m);
        chk1({tag, ".eject"}, coin_eject, e);
        chk1({tag, ".done"}, done, d);
    endtask

    task automatic push(input logic o, input logic [1:0] c);
        out    = o;
        change = c;
    endtask

    task automatic clear_in();
        out    = 1'b0;
        change = 2'b00;
    endtask

    task automatic idle_cyc(input string tag);
        chk_drv({tag, ".idle"}, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic motor_cycs(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk_drv({tag, ".mot"}, 1'b1, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic pulses(input string tag, input int n);
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < 2; j++) begin
                chk_drv({tag, ".ej_on"}, 1'b0, 1'b1, 1'b0);
                tick();
            end
            for (int j = 0; j < 2; j++) begin
                chk_drv({tag, ".ej_gap"}, 1'b0, 1'b0, 1'b0);
                tick();
            end
        end
    endtask

    task automatic done_cyc(input string tag);
        chk_drv({tag, ".donecyc"}, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic serve(input string tag, input int nm, input int np);
        idle_cyc(tag);
        motor_cycs(tag, nm);
        pulses(tag, np);
        done_cyc(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_in();
        hopper_empty = 1'b0;
        tick();
        chk_drv({tag, ".rst"}, 1'b0, 1'b0, 1'b0);
        chk1({tag, ".rst.busy"}, busy, 1'b0);
        chk1({tag, ".rst.ovf"}, overflow, 1'b0);
        chk1({tag, ".rst.short"}, coin_short, 1'b0);
        chk8({tag, ".rst.cnt"}, vend_cnt, 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] jobs [6];
        jobs[0] = 3'b001;
        jobs[1] = 3'b011;
        jobs[2] = 3'b100;
        jobs[3] = 3'b010;
        jobs[4] = 3'b111;
        jobs[5] = 3'b001;

        rst = 1'b1;
        clear_in();
        hopper_empty = 1'b0;
        tick();
        do_reset("init");

        // Vend only
        push(1'b1, 2'b00);
        tick();
        clear_in();
        chk1("vend.busy", busy, 1'b1);
        serve("vend", 8, 0);
        chk1("vend.end_busy", busy, 1'b0);
        chk8("vend.cnt", vend_cnt, EXP_AFTER_ONE);
        idle_cyc("vend.after");

        // Vend plus Rs10 change
        push(1'b1, 2'b10);
        tick();
        clear_in();
        serve("vend10", 8, 2);
        chk1("vend10.busy", busy, 1'b0);

        // Change only, Rs15
        push(1'b0, 2'b11);
        tick();
        clear_in();
        serve("chg15", 0, 3);
        chk1("chg15.short", coin_short, 1'b0);

        // Change only with empty hopper
        do_reset("r1");
        hopper_empty = 1'b1;
        push(1'b0, 2'b11);
        tick();
        clear_in();
        chk1("chg15e.short_pre", coin_short, 1'b0);
        serve("chg15e", 0, 0);
        chk1("chg15e.short", coin_short, 1'b1);
        hopper_empty = 1'b0;

        // Hopper empties during first pulse: pulse completes, second is skipped
        do_reset("r2");
        push(1'b1, 2'b10);
        tick();
        clear_in();
        idle_cyc("hmid");
        motor_cycs("hmid", 8);
        hopper_empty = 1'b1;
        pulses("hmid", 1);
        done_cyc("hmid");
        chk1("hmid.short", coin_short, 1'b1);
        hopper_empty = 1'b0;

        // Overflow: 6 jobs pushed while motor runs; 4 kept, 2 dropped
        do_reset("r3");
        push(1'b1, 2'b00);
        tick();
        clear_in();
        idle_cyc("ovf.a");
        for (int k = 0; k < 6; k++) begin
            push(jobs[k][2], jobs[k][1:0]);
            chk_drv("ovf.a.mot", 1'b1, 1'b0, 1'b0);
            tick();
        end
        clear_in();
        chk1("ovf.flag", overflow, 1'b1);
        motor_cycs("ovf.a", 2);
        done_cyc("ovf.a");
        serve("ovf.b", 0, 1);
        serve("ovf.c", 0, 3);
        serve("ovf.d", 8, 0);
        serve("ovf.e", 0, 2);
        idle_cyc("ovf.end");
        chk1("ovf.end_busy", busy, 1'b0);

        // Push into a full FIFO on the pop edge is accepted
        do_reset("r4");
        push(1'b0, 2'b01);
        tick();
        push(1'b0, 2'b10);
        chk_drv("fp.c0", 1'b0, 1'b0, 1'b0);
        tick();
        push(1'b0, 2'b11);
        chk_drv("fp.c1", 1'b0, 1'b1, 1'b0);
        tick();
        push(1'b1, 2'b00);
        chk_drv("fp.c2", 1'b0, 1'b1, 1'b0);
        tick();
        push(1'b0, 2'b01);
        chk_drv("fp.c3", 1'b0, 1'b0, 1'b0);
        tick();
        clear_in();
        chk_drv("fp.c4", 1'b0, 1'b0, 1'b0);
        tick();
        chk_drv("fp.c5", 1'b0, 1'b0, 1'b1);
        chk1("fp.ovf_pre", overflow, 1'b0);
        tick();
        push(1'b0, 2'b10);
        chk_drv("fp.c6", 1'b0, 1'b0, 1'b0);
        tick();
        clear_in();
        chk1("fp.ovf", overflow, 1'b0);
        pulses("fp.j1", 2);
        done_cyc("fp.j1");
        serve("fp.j2", 0, 3);
        serve("fp.j3", 8, 0);
        serve("fp.j4", 0, 1);
        serve("fp.j5", 0, 2);
        idle_cyc("fp.end");
        chk1("fp.end_busy", busy, 1'b0);
        chk1("fp.end_ovf", overflow, 1'b0);

        // Reset during the second ejector pulse; the job offered on the reset edge is ignored
        push(1'b0, 2'b11);
        tick();
        clear_in();
        idle_cyc("rmid");
        pulses("rmid", 1);
        chk_drv("rmid.p2", 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        push(1'b1, 2'b00);
        tick();
        chk_drv("rmid.after", 1'b0, 1'b0, 1'b0);
        chk1("rmid.busy", busy, 1'b0);
        rst = 1'b0;
        clear_in();
        tick();
        chk_drv("rmid.after2", 1'b0, 1'b0, 1'b0);
        chk1("rmid.busy2", busy, 1'b0);
        idle_cyc("rmid.after3");
        chk1("rmid.busy3", busy, 1'b0);

        // Vend counter saturation (or constant 0 when stats are not built)
        do_reset("r5");
        for (int v = 0; v < N_VENDS; v++) begin
            push(1'b1, 2'b00);
            tick();
            clear_in();
            repeat (10) tick();
        end
        chk1("stats.busy", busy, 1'b0);
        chk8("stats.cnt", vend_cnt, EXP_AFTER_N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 SHALL have parameter MOTOR_CYC, default 8, product-motor on-time in clock cycles (legal 1..255).
REQ-002 SHALL have parameter EJECT_ON, default 2, coin-ejector pulse width in cycles (legal 1..15).
REQ-003 SHALL have parameter EJECT_GAP, default 2, minimum low time between ejector pulses in cycles (legal 1..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port out  input  1  vend strobe from upstream controller (1 = dispense product).
REQ-007 SHALL have port change  input  2  upstream change code (00 none, 01 Rs5, 10 Rs10, 11 Rs15).
REQ-008 SHALL have port hopper_empty  input  1  coin hopper has no Rs5 coins.
REQ-009 SHALL have port prod_motor  output  1  product motor drive.
REQ-010 SHALL have port coin_eject  output  1  Rs5 coin ejector drive; one pulse = one coin.
REQ-011 SHALL have port busy  output  1  FSM not IDLE or FIFO not empty.
REQ-012 SHALL have port done  output  1  one-cycle pulse at job completion.
REQ-013 SHALL have port overflow  output  1  sticky, request dropped because FIFO full.
REQ-014 SHALL have port coin_short  output  1  sticky, change not fully paid due to hopper_empty.
REQ-015 SHALL have port vend_cnt  output  8  dispensed-product count (see Configuration).

Function
REQ-016 A job SHALL be captured on every rising edge where out=1 or change!=00; entry = {out, change}, 3 bits.
REQ-017 Jobs SHALL be buffered in a 4-entry FIFO, in order; push when full SHALL drop the job and set overflow.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when full (no drop) or empty (no bypass; job waits one cycle).
REQ-019 FSM states SHALL be IDLE, MOTOR, EJ_ON, EJ_GAP, DONE; outputs Moore-decoded from state.
REQ-020 IDLE: if FIFO non-empty, pop at the edge; go MOTOR if vend bit=1, else EJ_ON with coins = change code (1..3).
REQ-021 MOTOR: prod_motor=1 for exactly MOTOR_CYC cycles; then EJ_ON if coins>0, else DONE.
REQ-022 EJ_ON: coin_eject=1 for exactly EJECT_ON cycles, coins decremented at exit; then EJ_GAP.
REQ-023 EJ_GAP: both drives low for exactly EJECT_GAP cycles; then EJ_ON if coins>0, else DONE.
REQ-024 hopper_empty=1 on the edge that would enter EJ_ON SHALL skip all remaining coins, set coin_short, go DONE; hopper_empty during EJ_ON/EJ_GAP SHALL not cut a pulse short.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Latency: job sampled at edge E0 is written at E0, popped at E1; first drive output high in the cycle after E1.
REQ-027 prod_motor and coin_eject SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, empty FIFO, coins=0, and clear overflow, coin_short and vend_cnt.
REQ-029 After reset all outputs SHALL be 0; reset mid-job SHALL abandon the job with drives low on the next cycle.
REQ-030 Inputs sampled on a reset edge SHALL not be captured.

Configuration
REQ-031 With DISPENSE_STATS_EN defined, vend_cnt SHALL increment when MOTOR completes and saturate at 255.
REQ-032 Without DISPENSE_STATS_EN, vend_cnt SHALL be constant 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-033 out=1, change=00 one cycle -> prod_motor high 8 cycles starting 2 cycles after the strobe edge, then done for 1 cycle; coin_eject stays 0.
REQ-034 out=1, change=10 -> 8 motor cycles, then 2 ejector pulses of 2 cycles each separated by 2 low cycles, then done.
REQ-035 out=0, change=11, hopper_empty=0 -> 3 ejector pulses, no motor, done; the same job with hopper_empty=1 -> 0 pulses, coin_short=1, done.
REQ-036 6 back-to-back jobs while the FSM is busy -> first 4 beyond the popped job are served in order, the rest dropped, overflow=1.
REQ-037 rst asserted during the 2nd ejector pulse -> all outputs 0 next cycle, FIFO empty; with DISPENSE_STATS_EN, 300 vends -> vend_cnt=255.
